// File: rtl/tpg_pkg.sv
// tpg_pkg: v_tpg register map, ap_ctrl bits and the sequencer/bus-engine state types.
// Rev 1.0
`default_nettype none

package tpg_pkg;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_HEIGHT    = 8'h10;
  localparam logic [7:0] REG_WIDTH     = 8'h18;
  localparam logic [7:0] REG_PATTERN   = 8'h20;
  localparam logic [7:0] REG_FORMAT    = 8'h40;
  localparam logic [7:0] REG_INTERLACE = 8'hD0;

  localparam int AP_START_BIT        = 0;
  localparam int AP_IDLE_BIT         = 2;
  localparam int AP_AUTO_RESTART_BIT = 7;

  localparam logic [31:0] CTRL_RUN     = (32'h1 << AP_AUTO_RESTART_BIT) | (32'h1 << AP_START_BIT);
  localparam logic [31:0] AP_IDLE_MASK = 32'h1 << AP_IDLE_BIT;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_START,
    ST_RUN,
    ST_PAT_WR,
    ST_STOP_WR,
    ST_POLL,
    ST_POLL_WAIT
  } seq_state_t;

  typedef enum logic [2:0] {
    M_IDLE,
    M_WR_BOTH,
    M_WR_AW,
    M_WR_W,
    M_WR_B,
    M_RD_AR,
    M_RD_R
  } axil_state_t;

endpackage

`default_nettype wire

// File: rtl/tpg_pattern_sequencer_if.sv
// tpg_pattern_sequencer_if: AXI4-Lite control bus towards the v_tpg s_axi_CTRL port.
// Rev 1.0
`default_nettype none

interface tpg_pattern_sequencer_if;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/axil_single_master.sv
// axil_single_master: one-shot AXI4-Lite write/read engine, one transaction in flight.
// Rev 1.0
`default_nettype none

module axil_single_master
  import tpg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  tpg_pattern_sequencer_if.master axi
);

  axil_state_t state;
  axil_state_t state_nxt;
  logic        b_hs;
  logic        r_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= M_IDLE;
    else        state <= state_nxt;
  end

  // AW and W are tracked separately so each drops on its own handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      M_IDLE:    if (req) state_nxt = we ? M_WR_BOTH : M_RD_AR;
      M_WR_BOTH: begin
        if (axi.awready && axi.wready) state_nxt = M_WR_B;
        else if (axi.awready)          state_nxt = M_WR_W;
        else if (axi.wready)           state_nxt = M_WR_AW;
      end
      M_WR_AW:   if (axi.awready) state_nxt = M_WR_B;
      M_WR_W:    if (axi.wready)  state_nxt = M_WR_B;
      M_WR_B:    if (axi.bvalid)  state_nxt = M_IDLE;
      M_RD_AR:   if (axi.arready) state_nxt = M_RD_R;
      M_RD_R:    if (axi.rvalid)  state_nxt = M_IDLE;
      default:   state_nxt = M_IDLE;
    endcase
  end

  // Every VALID/READY is decoded from the state register only.
  assign axi.awvalid = (state == M_WR_BOTH) || (state == M_WR_AW);
  assign axi.wvalid  = (state == M_WR_BOTH) || (state == M_WR_W);
  assign axi.bready  = (state == M_WR_B);
  assign axi.arvalid = (state == M_RD_AR);
  assign axi.rready  = (state == M_RD_R);
  assign axi.wstrb   = 4'hF;

  assign b_hs = (state == M_WR_B) && axi.bvalid;
  assign r_hs = (state == M_RD_R) && axi.rvalid;
  assign ack  = b_hs || r_hs;
  assign err  = (b_hs && (axi.bresp != AXI_OKAY)) || (r_hs && (axi.rresp != AXI_OKAY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi.awaddr <= 8'h00;
      axi.wdata  <= 32'h0;
      axi.araddr <= 8'h00;
      rdata      <= 32'h0;
    end else begin
      if ((state == M_IDLE) && req) begin
        if (we) begin
          axi.awaddr <= addr;
          axi.wdata  <= wdata;
        end else begin
          axi.araddr <= addr;
        end
      end
      if (r_hs) rdata <= axi.rdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tpg_pattern_sequencer.sv
// tpg_pattern_sequencer: configures v_tpg over AXI4-Lite, rotates patterns every N frames,
// and performs a clean stop on disable. Rev 1.0
`default_nettype none

module tpg_pattern_sequencer
  import tpg_pkg::*;
#(
  parameter int                          ACTIVE_LINES       = 720,
  parameter int                          ACTIVE_PIXELS      = 1280,
  parameter int                          COLOR_FMT          = 2,
  parameter int                          NUM_PATTERNS       = 4,
  parameter logic [8*NUM_PATTERNS-1:0]   PATTERN_LIST       = 32'h0A090201,
  parameter int                          FRAMES_PER_PATTERN = 60
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic       sof_i,
  tpg_pattern_sequencer_if.master m_axi_ctrl,
  output logic       done_o,
  output logic [7:0] pattern_o,
  output logic       err_o
);

  localparam int             CW         = $clog2(FRAMES_PER_PATTERN + 1);
  localparam logic [CW-1:0]  LAST_FRAME = CW'(FRAMES_PER_PATTERN - 1);
  localparam logic [3:0]     IDX_LAST   = 4'(NUM_PATTERNS - 1);

  seq_state_t     state;
  seq_state_t     state_nxt;
  logic           req;
  logic           we;
  logic [7:0]     addr;
  logic [31:0]    wdata;
  logic           ack;
  logic [31:0]    rdata;
  logic           m_err;
  logic           busy;
  logic [2:0]     cfg_step;
  logic [CW-1:0]  frame_cnt;
  logic [3:0]     idx;
  logic [3:0]     wait_cnt;
  logic           rotate;
  logic           core_idle;
  logic [7:0]     pat_tbl [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_pat
    if (gi < NUM_PATTERNS) begin : g_used
      assign pat_tbl[gi] = PATTERN_LIST[gi*8 +: 8];
    end else begin : g_unused
      assign pat_tbl[gi] = 8'h00;
    end
  end

  axil_single_master u_master (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack),
    .rdata (rdata),
    .err   (m_err),
    .axi   (m_axi_ctrl)
  );

  assign rotate    = (state == ST_RUN) && enable_i && sof_i && (frame_cnt == LAST_FRAME);
  assign core_idle = |(rdata & AP_IDLE_MASK);
  assign done_o    = (state == ST_RUN) || (state == ST_PAT_WR);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // req is held off while a transaction is outstanding (busy) so each access issues once.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    we        = 1'b1;
    addr      = REG_CTRL;
    wdata     = 32'h0;
    case (state)
      ST_IDLE: if (enable_i) state_nxt = ST_CFG;
      ST_CFG: begin
        req = !busy;
        case (cfg_step)
          3'd0:    begin addr = REG_HEIGHT;    wdata = 32'(ACTIVE_LINES);    end
          3'd1:    begin addr = REG_WIDTH;     wdata = 32'(ACTIVE_PIXELS);   end
          3'd2:    begin addr = REG_PATTERN;   wdata = {24'h0, pat_tbl[idx]}; end
          3'd3:    begin addr = REG_FORMAT;    wdata = 32'(COLOR_FMT);       end
          default: begin addr = REG_INTERLACE; wdata = 32'h0;                end
        endcase
        if (ack && (cfg_step == 3'd4)) state_nxt = ST_START;
      end
      ST_START: begin
        req   = !busy;
        wdata = CTRL_RUN;
        if (ack) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!enable_i)   state_nxt = ST_STOP_WR;
        else if (rotate) state_nxt = ST_PAT_WR;
      end
      ST_PAT_WR: begin
        req   = !busy;
        addr  = REG_PATTERN;
        wdata = {24'h0, pat_tbl[idx]};
        if (ack) state_nxt = ST_RUN;
      end
      ST_STOP_WR: begin
        req = !busy;
        if (ack) state_nxt = ST_POLL;
      end
      ST_POLL: begin
        req = !busy;
        we  = 1'b0;
        if (ack) state_nxt = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        // rdata holds the value captured by the last poll read.
        if (core_idle)              state_nxt = ST_IDLE;
        else if (wait_cnt == 4'd15) state_nxt = ST_POLL;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy      <= 1'b0;
      cfg_step  <= 3'd0;
      frame_cnt <= '0;
      idx       <= 4'd0;
      wait_cnt  <= 4'd0;
      pattern_o <= PATTERN_LIST[7:0];
      err_o     <= 1'b0;
    end else begin
      if (ack)      busy <= 1'b0;
      else if (req) busy <= 1'b1;

      if (m_err) err_o <= 1'b1;

      if ((state == ST_CFG) && ack)
        cfg_step <= (cfg_step == 3'd4) ? 3'd0 : cfg_step + 3'd1;

      if (ack && ((state == ST_PAT_WR) || ((state == ST_CFG) && (cfg_step == 3'd2))))
        pattern_o <= pat_tbl[idx];

      wait_cnt <= (state == ST_POLL_WAIT) ? wait_cnt + 4'd1 : 4'd0;

      if ((state == ST_START) && ack)
        frame_cnt <= '0;
      else if ((state == ST_RUN) && enable_i && sof_i)
        frame_cnt <= rotate ? '0 : frame_cnt + CW'(1);
      else if ((state == ST_PAT_WR) && sof_i && (frame_cnt != LAST_FRAME))
        frame_cnt <= frame_cnt + CW'(1);

      if (rotate) idx <= (idx == IDX_LAST) ? 4'd0 : idx + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tpg_pattern_sequencer.sv
// tb_tpg_pattern_sequencer: directed/random bench with a behavioural AXI4-Lite slave and
// a frame-count based model of the expected register writes.
`default_nettype none

module tb_tpg_pattern_sequencer;

  localparam int          FPP   = 2;
  localparam int          NUM   = 4;
  localparam logic [31:0] PLIST = 32'h0A090201;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       sof = 1'b0;
  logic       done;
  logic       err;
  logic [7:0] pattern;

  tpg_pattern_sequencer_if axi ();

  tpg_pattern_sequencer #(
    .ACTIVE_LINES       (720),
    .ACTIVE_PIXELS      (1280),
    .COLOR_FMT          (2),
    .NUM_PATTERNS       (NUM),
    .PATTERN_LIST       (PLIST),
    .FRAMES_PER_PATTERN (FPP)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .enable_i   (enable),
    .sof_i      (sof),
    .m_axi_ctrl (axi),
    .done_o     (done),
    .pattern_o  (pattern),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  longint      cyc = 0;
  int          max_stall = 0;
  bit          hold_aw = 1'b0;
  bit          err_inj = 1'b0;
  logic [39:0] wlog [$];
  longint      reads [$];
  logic [31:0] poll_q [$];
  int          aw_hs = 0;
  int          w_hs = 0;

  bit          aw_have, w_have, b_pend, r_pend;
  logic [7:0]  aw_addr;
  logic [31:0] w_data, r_val;
  logic [1:0]  b_resp;
  int          aw_stall, w_stall, b_stall, ar_stall, r_stall;

  function automatic logic [7:0] pat(input int i);
    logic [31:0] t;
    t = PLIST >> (8 * i);
    return t[7:0];
  endfunction

  function automatic logic [39:0] cfg_entry(input int i, input logic [7:0] p);
    case (i)
      0:       return {8'h10, 32'd720};
      1:       return {8'h18, 32'd1280};
      2:       return {8'h20, 24'h0, p};
      3:       return {8'h40, 32'd2};
      4:       return {8'hD0, 32'd0};
      default: return {8'h00, 32'h81};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cfg(input string tag, input logic [7:0] p);
    chk({tag, "_count"}, 64'(wlog.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_wr%0d", tag, i), (i < wlog.size()) ? wlog[i] : 40'hFFFFFFFFFF, cfg_entry(i, p));
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic pulse_sof();
    @(negedge clk) sof = 1'b1;
    @(negedge clk) sof = 1'b0;
  endtask

  initial forever @(posedge clk) cyc++;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Behavioural AXI4-Lite slave; decisions made on negedge take effect at the next posedge.
  initial begin : slave
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00;
    aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
    aw_stall = 0; w_stall = 0; b_stall = 0; ar_stall = 0; r_stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
        aw_stall = 0; w_stall = 0; b_stall = 0; ar_stall = 0; r_stall = 0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.arready = 1'b0; axi.rvalid = 1'b0;
      end else begin
        axi.bvalid = b_pend && (b_stall == 0);
        axi.bresp  = b_resp;
        if (axi.bvalid && axi.bready) b_pend = 0;
        else if (b_pend && b_stall > 0) b_stall--;

        axi.rvalid = r_pend && (r_stall == 0);
        axi.rdata  = r_val;
        if (axi.rvalid && axi.rready) begin
          r_pend = 0;
          reads.push_back(cyc);
        end else if (r_pend && r_stall > 0) r_stall--;

        axi.awready = (aw_stall == 0) && !hold_aw;
        if (axi.awvalid && axi.awready) begin
          aw_have = 1; aw_addr = axi.awaddr; aw_hs++;
          aw_stall = $urandom_range(0, max_stall);
        end else if (axi.awvalid && aw_stall > 0) aw_stall--;

        axi.wready = (w_stall == 0);
        if (axi.wvalid && axi.wready) begin
          w_have = 1; w_data = axi.wdata; w_hs++;
          w_stall = $urandom_range(0, max_stall);
        end else if (axi.wvalid && w_stall > 0) w_stall--;

        if (aw_have && w_have) begin
          wlog.push_back({aw_addr, w_data});
          aw_have = 0; w_have = 0; b_pend = 1;
          b_stall = $urandom_range(0, max_stall);
          b_resp  = (err_inj && aw_addr == 8'h40) ? 2'b10 : 2'b00;
        end

        axi.arready = (ar_stall == 0);
        if (axi.arvalid && axi.arready) begin
          r_pend  = 1;
          r_stall = $urandom_range(0, max_stall);
          r_val   = (poll_q.size() > 0) ? poll_q.pop_front() : 32'h4;
          ar_stall = $urandom_range(0, max_stall);
        end else if (axi.arvalid && ar_stall > 0) ar_stall--;
      end
    end
  end

  initial begin : main
    int rot;
    int sofs;
    int n;
    rot = 0;
    sofs = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pattern", 64'(pattern), 64'h01);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_valid_ready", 64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 64'd0);
    chk("rst_addr_data", 64'({axi.awaddr, axi.wdata, axi.araddr}), 64'd0);
    chk("wstrb", 64'(axi.wstrb), 64'hF);

    // Configuration with a zero-wait slave
    rst_n = 1'b1;
    @(negedge clk) enable = 1'b1;
    wait_done("cfg0_done", 200);
    expect_cfg("cfg0", pat(0));
    chk("cfg0_pattern", 64'(pattern), 64'(pat(0)));
    chk("cfg0_err", 64'(err), 64'd0);

    // Pattern rotation: one PATTERN write every FPP start-of-frame beats
    wlog.delete();
    for (int p = 0; p < 8; p++) begin
      pulse_sof();
      sofs++;
      repeat (10) @(negedge clk);
      if (sofs % FPP == 0) begin
        rot++;
        chk($sformatf("rot%0d_pattern", rot), 64'(pattern), 64'(pat(rot % NUM)));
      end
    end
    chk("rot_count", 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rot_wr%0d", i), (i < wlog.size()) ? wlog[i] : 40'hFFFFFFFFFF,
          {8'h20, 24'h0, pat((i + 1) % NUM)});

    // Clean stop: busy, busy, idle
    wlog.delete();
    reads.delete();
    poll_q.push_back(32'h0);
    poll_q.push_back(32'h0);
    poll_q.push_back(32'h4);
    @(negedge clk) enable = 1'b0;
    n = 0;
    while (reads.size() < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    chk("stop_reads", 64'(reads.size()), 64'd3);
    if (reads.size() >= 3) begin
      chk("stop_gap1", 64'((reads[1] - reads[0]) >= 16), 64'd1);
      chk("stop_gap2", 64'((reads[2] - reads[1]) >= 16), 64'd1);
    end
    chk("stop_wr_count", 64'(wlog.size()), 64'd1);
    chk("stop_wr0", (wlog.size() > 0) ? wlog[0] : 40'hFFFFFFFFFF, 40'h0);
    chk("stop_done", 64'(done), 64'd0);
    chk("stop_arvalid", 64'(axi.arvalid), 64'd0);

    // Restart under random stalls with an error response on FORMAT
    wlog.delete();
    aw_hs = 0;
    w_hs = 0;
    max_stall = 7;
    err_inj = 1'b1;
    @(negedge clk) enable = 1'b1;
    wait_done("cfg1_done", 3000);
    expect_cfg("cfg1", pat(rot % NUM));
    chk("cfg1_aw_hs", 64'(aw_hs), 64'd6);
    chk("cfg1_w_hs", 64'(w_hs), 64'd6);
    chk("cfg1_err", 64'(err), 64'd1);
    chk("cfg1_pattern", 64'(pattern), 64'(pat(rot % NUM)));
    err_inj = 1'b0;
    repeat (20) @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);

    // Asynchronous reset while AWVALID is high
    max_stall = 0;
    hold_aw = 1'b1;
    pulse_sof();
    repeat (3) @(negedge clk);
    pulse_sof();
    n = 0;
    while (axi.awvalid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("arst_awvalid_seen", 64'(axi.awvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid_ready", 64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_addr_data", 64'({axi.awaddr, axi.wdata}), 64'd0);
    repeat (3) @(negedge clk);
    hold_aw = 1'b0;
    wlog.delete();
    rst_n = 1'b1;
    wait_done("cfg2_done", 200);
    expect_cfg("cfg2", pat(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
